// File: rtl/instruction_fetch_pkg.sv
// Shared processor constants for the fetch unit.
// FSM encodings and the default boot address.
package instruction_fetch_pkg;

  localparam int unsigned IF_RESET_PC = 0;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_RUN  = 2'd1,
    IF_HOLD = 2'd2
  } if_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: drives a 1-cycle sync ROM and
// presents instructions with stall hold and redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 12,
  parameter int unsigned RESET_PC   = IF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_q,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic [31:0]           fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC =
    ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0] pc, pc_nx;
  logic [ADDR_WIDTH-1:0] f_pc, f_pc_nx;
  logic [DATA_WIDTH-1:0] hold_instr, hold_nx;
  if_state_t             state, state_nx;
  logic                  accept;
  logic                  advance;
  logic                  capture;

  assign imem_addr   = pc;
  assign instr_valid = (state != IF_IDLE);
  assign instr_pc    = f_pc;
  assign instr       = (state == IF_HOLD) ?
                       hold_instr : imem_q;

  assign accept  = instr_valid && !stall;
  assign advance = !redirect &&
                   ((state == IF_IDLE) || accept);
  assign capture = !redirect && stall &&
                   (state == IF_RUN);

  always_comb begin
    pc_nx    = pc;
    f_pc_nx  = f_pc;
    hold_nx  = hold_instr;
    state_nx = state;
    unique case (1'b1)
      redirect: begin
        pc_nx    = redirect_addr;
        state_nx = IF_IDLE;
      end
      advance: begin
        f_pc_nx  = pc;
        pc_nx    = pc + ADDR_WIDTH'(1);
        state_nx = IF_RUN;
      end
      capture: begin
        hold_nx  = imem_q;
        state_nx = IF_HOLD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RST_PC;
      f_pc        <= '0;
      hold_instr  <= '0;
      state       <= IF_IDLE;
      fetch_count <= '0;
    end else begin
      pc         <= pc_nx;
      f_pc       <= f_pc_nx;
      hold_instr <= hold_nx;
      state      <= state_nx;
      // Redirect squashes the presented instruction.
      if (accept && !redirect)
        fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch with a 1-cycle ROM
// model and a scoreboard of expected instructions.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] imem_addr;
  logic [31:0] imem_q = '0;
  logic        stall;
  logic        redirect;
  logic [11:0] redirect_addr;
  logic [31:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic [31:0] fetch_count;

  typedef struct {
    logic [11:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          pass_cnt = 0;
  int          total    = 0;
  logic [31:0] exp_cnt  = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    imem_q <= 32'hA000_0000 + 32'(imem_addr);

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_q        (imem_q),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .fetch_count   (fetch_count)
  );

  function automatic exp_t mk(input logic [11:0] p);
    exp_t r;
    r.pc  = p;
    r.ins = 32'hA000_0000 + 32'(p);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    repeat (2) @(negedge clk);
    total++;
    if (instr_valid !== 1'b0)
      $display("FAIL rst_valid got %b want 0", instr_valid);
    else pass_cnt++;
    total++;
    if (imem_addr !== 12'd0)
      $display("FAIL rst_addr got %0d want 0", imem_addr);
    else pass_cnt++;
    total++;
    if (fetch_count !== 32'd0)
      $display("FAIL rst_cnt got %0d want 0", fetch_count);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back(mk(12'(i)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== e.pc ||
          instr !== e.ins)
        $display("FAIL boot v=%b pc=%0d ins=%h want pc=%0d ins=%h",
                 instr_valid, instr_pc, instr, e.pc, e.ins);
      else pass_cnt++;
      if (i == 4) begin
        total++;
        if (fetch_count !== exp_cnt)
          $display("FAIL boot_cnt got %0d want %0d",
                   fetch_count, exp_cnt);
        else pass_cnt++;
      end
      exp_cnt++;
    end
  endtask

  task automatic test_stall();
    sb.push_back(mk(12'd5));
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== e.pc ||
        instr !== e.ins)
      $display("FAIL stall_pre pc=%0d ins=%h want pc=%0d ins=%h",
               instr_pc, instr, e.pc, e.ins);
    else pass_cnt++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== e.pc ||
          instr !== e.ins)
        $display("FAIL stall_hold%0d v=%b pc=%0d ins=%h want pc=%0d ins=%h",
                 i, instr_valid, instr_pc, instr, e.pc, e.ins);
      else pass_cnt++;
    end
    stall = 1'b0;
    exp_cnt++;
    sb.push_back(mk(12'd6));
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== e.pc ||
        instr !== e.ins)
      $display("FAIL stall_post v=%b pc=%0d ins=%h want pc=%0d",
               instr_valid, instr_pc, instr, e.pc);
    else pass_cnt++;
    total++;
    if (fetch_count !== exp_cnt)
      $display("FAIL stall_cnt got %0d want %0d",
               fetch_count, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_redirect();
    for (int p = 7; p <= 10; p++) begin
      sb.push_back(mk(12'(p)));
      exp_cnt++;
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== e.pc ||
          instr !== e.ins)
        $display("FAIL run pc=%0d ins=%h want pc=%0d ins=%h",
                 instr_pc, instr, e.pc, e.ins);
      else pass_cnt++;
    end
    redirect = 1'b1;
    redirect_addr = 12'd1124;
    @(negedge clk);
    redirect = 1'b0;
    total++;
    if (instr_valid !== 1'b0)
      $display("FAIL redir_bubble got %b want 0", instr_valid);
    else pass_cnt++;
    sb.push_back(mk(12'd1124));
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== e.pc ||
        instr !== e.ins)
      $display("FAIL redir_tgt v=%b pc=%0d ins=%h want pc=%0d ins=%h",
               instr_valid, instr_pc, instr, e.pc, e.ins);
    else pass_cnt++;
    total++;
    if (fetch_count !== exp_cnt)
      $display("FAIL redir_cnt got %0d want %0d",
               fetch_count, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_redirect_in_hold();
    stall = 1'b1;
    @(negedge clk);
    total++;
    if (instr_pc !== 12'd1124 || instr !== 32'hA000_0464)
      $display("FAIL hold_pre pc=%0d ins=%h want pc=1124 ins=a0000464",
               instr_pc, instr);
    else pass_cnt++;
    redirect = 1'b1;
    redirect_addr = 12'd200;
    @(negedge clk);
    redirect = 1'b0;
    total++;
    if (instr_valid !== 1'b0)
      $display("FAIL hold_redir_bubble got %b want 0",
               instr_valid);
    else pass_cnt++;
    sb.push_back(mk(12'd200));
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== e.pc ||
        instr !== e.ins)
      $display("FAIL hold_redir_tgt v=%b pc=%0d ins=%h want pc=%0d ins=%h",
               instr_valid, instr_pc, instr, e.pc, e.ins);
    else pass_cnt++;
    total++;
    if (fetch_count !== exp_cnt)
      $display("FAIL hold_redir_cnt got %0d want %0d",
               fetch_count, exp_cnt);
    else pass_cnt++;
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    redirect = 1'b1;
    redirect_addr = 12'd4094;
    @(negedge clk);
    redirect = 1'b0;
    total++;
    if (instr_valid !== 1'b0)
      $display("FAIL wrap_bubble got %b want 0", instr_valid);
    else pass_cnt++;
    sb.push_back(mk(12'd4094));
    sb.push_back(mk(12'd4095));
    sb.push_back(mk(12'd0));
    sb.push_back(mk(12'd1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== e.pc ||
          instr !== e.ins)
        $display("FAIL wrap%0d v=%b pc=%0d ins=%h want pc=%0d ins=%h",
                 i, instr_valid, instr_pc, instr, e.pc, e.ins);
      else pass_cnt++;
      if (i == 3) begin
        total++;
        if (fetch_count !== exp_cnt)
          $display("FAIL wrap_cnt got %0d want %0d",
                   fetch_count, exp_cnt);
        else pass_cnt++;
      end
      exp_cnt++;
    end
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    @(negedge clk);
    total++;
    if (instr_pc !== 12'd1 || instr !== 32'hA000_0001)
      $display("FAIL ar_hold pc=%0d ins=%h want pc=1 ins=a0000001",
               instr_pc, instr);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || imem_addr !== 12'd0 ||
        fetch_count !== 32'd0)
      $display("FAIL ar_now v=%b addr=%0d cnt=%0d want 0/0/0",
               instr_valid, imem_addr, fetch_count);
    else pass_cnt++;
    exp_cnt = 0;
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(12'd0));
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== e.pc ||
        instr !== e.ins)
      $display("FAIL ar_boot v=%b pc=%0d ins=%h want pc=%0d ins=%h",
               instr_valid, instr_pc, instr, e.pc, e.ins);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_in_hold();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, word-address width (4096 words).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset (the initial jump slot).
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port imem_addr, output, ADDR_WIDTH, word address to the synchronous instruction ROM.
REQ-007 SHALL have port imem_q, input, DATA_WIDTH, ROM data; equals the word at imem_addr sampled on the previous edge.
REQ-008 SHALL have port stall, input, 1, consumer not accepting the presented instruction this cycle.
REQ-009 SHALL have port redirect, input, 1, load a new PC (branch, jump, context switch).
REQ-010 SHALL have port redirect_addr, input, ADDR_WIDTH, target word address for redirect.
REQ-011 SHALL have port instr, output, DATA_WIDTH, presented instruction.
REQ-012 SHALL have port instr_pc, output, ADDR_WIDTH, word address of instr.
REQ-013 SHALL have port instr_valid, output, 1, instr/instr_pc meaningful this cycle.
REQ-014 SHALL have port fetch_count, output, 32, count of accepted instructions.

Function
REQ-015 SHALL hold registers pc (next address), f_pc (address in flight), hold_instr, fetch_count, and a 3-state FSM: IDLE, RUN, HOLD.
REQ-016 SHALL drive imem_addr = pc combinationally from the register.
REQ-017 SHALL drive instr_valid = 1 in RUN and HOLD, 0 in IDLE; instr_pc = f_pc.
REQ-018 SHALL drive instr = hold_instr in HOLD, imem_q otherwise.
REQ-019 SHALL define accept = instr_valid and not stall; fetch_count increments by 1 on each accept and wraps at 2^32.
REQ-020 SHALL, on an edge with advance (IDLE, or accept, with no redirect), set f_pc <= pc, pc <= pc+1 modulo 2^ADDR_WIDTH, state <= RUN.
REQ-021 SHALL, in RUN with stall=1 and no redirect, capture imem_q into hold_instr, hold pc and f_pc, and go to HOLD.
REQ-022 SHALL, in HOLD with stall=1 and no redirect, hold all registers; with stall=0, advance per REQ-020 with no bubble.
REQ-023 SHALL, on redirect=1 in any state, set pc <= redirect_addr and state <= IDLE, discarding any in-flight or held instruction.
REQ-024 SHALL give redirect priority over stall; an instruction presented in the same cycle as redirect is not counted.
REQ-025 SHALL ignore stall while instr_valid=0.
REQ-026 SHALL have a redirect latency of exactly one bubble cycle: instr_valid=1 with instr_pc=redirect_addr on the second cycle after the redirect edge.
REQ-027 SHALL wrap pc from 2^ADDR_WIDTH-1 to 0 without a bubble.

Reset
REQ-028 SHALL, while rst_n=0, force pc=RESET_PC, f_pc=0, hold_instr=0, fetch_count=0, and state=IDLE (instr_valid=0, imem_addr=RESET_PC).
REQ-029 SHALL present instr_valid=1, instr_pc=RESET_PC after the first rising edge following rst_n release.
REQ-030 SHALL, on reset assertion mid-HOLD or mid-redirect, drop all fetch state immediately.

Structure
REQ-031 SHALL take FSM state encodings and the RESET_PC default from the shared processor constants file; no typedefs are required.
REQ-032 SHALL be a single module with no sub-modules; the ROM is instantiated by the parent.

Verification (bench SHALL model a 1-cycle synchronous ROM where rom[i] = 32'hA000_0000 + i)
REQ-033 SHALL cover reset release with stall=0 for 4 cycles -> instr_pc 0,1,2,3 with instr A000_0000..A000_0003, fetch_count=4.
REQ-034 SHALL cover stall held 3 cycles while instr_pc=5 -> instr A000_0005 stable throughout, then instr_pc=6 on the next cycle with no bubble, and 5 counted once.
REQ-035 SHALL cover redirect to 1124 while at instr_pc=10 -> one instr_valid=0 cycle, then instr_pc=1124, instr A000_0464; instr_pc 10 is not counted.
REQ-036 SHALL cover redirect and stall together while in HOLD -> held instruction discarded, next valid instr_pc=redirect_addr.
REQ-037 SHALL cover redirect to 4094 with no stall -> instr_pc 4094, 4095, 0, 1 in consecutive cycles.
REQ-038 SHALL cover rst_n asserted asynchronously mid-HOLD -> instr_valid=0 and imem_addr=RESET_PC before the next edge.
